jtag_debug_cmd_sysclk_fifo: RTL
===============================

Name: jtag_debug_cmd_sysclk_fifo

Overview:
- Parametrised system-clock side of the CPU debug slave, generalising the fixed 2-bit-IR / 38-bit-SR sysclk capture stage.
- Synchronises update-IR and exit1-DR toggle events from the TCK domain and captures the shift register plus the IR on each DR event.
- Buffers captured commands in a FIFO with a valid/ready pop interface.
- Emits one-cycle per-channel take_action / take_no_action strobes on each pop.

Parameters:
- SR_W, 38, shift-register / jdo width.
- IR_W, 2, instruction-register width. NUM_CH = 2**IR_W (derived, not overridable).
- ACT_BIT, 34, index in the captured SR selecting action (1) vs no-action (0). Must be < SR_W.
- SYNC_STAGES, 2, synchroniser depth (>=2).
- FIFO_DEPTH, 4, command FIFO entries. Power of 2, >=2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- uir_tgl  in  1  TCK-domain toggle; each level change = one update-IR event.
- e1dr_tgl  in  1  TCK-domain toggle; each level change = one exit1-DR event.
- ir_in  in  IR_W  TCK-domain IR, quasi-static around events.
- sr  in  SR_W  TCK-domain shift register, quasi-static around events.
- cmd_valid  out  1  FIFO non-empty.
- cmd_ready  in  1  consumer pop request.
- cmd_ir  out  IR_W  head-entry IR.
- cmd_jdo  out  SR_W  head-entry captured SR.
- ir_q  out  IR_W  IR latched at the last update-IR event.
- ir_upd  out  1  one-cycle strobe on each update-IR event.
- take_action  out  NUM_CH  one-hot one-cycle strobe.
- take_no_action  out  NUM_CH  one-hot one-cycle strobe.
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy.
- ovf  out  1  sticky overflow flag.
- clr_ovf  in  1  clears ovf.

Behaviour:
- Reset values. While reset is high, every output is 0, the FIFO is empty, and all sync/prev flops are 0.
- Synchroniser. Each toggle passes through a SYNC_STAGES flop chain s[0..S-1]. A register p follows s[S-1], and event = s[S-1] ^ p.
- Latency. A toggle change set up before edge k produces an event during the cycle after edge k+S-1. The action (push or latch) occurs at edge k+S, so with S=2 cmd_valid rises after edge k+2.
- Post-reset priming. A counter loaded with SYNC_STAGES+1 at reset decrements each cycle. Events are suppressed while it is non-zero, so a toggle already at 1 never produces a spurious event. p still tracks s[S-1] during priming.
- update-IR event. At the action edge, ir_q <= ir_in, and ir_upd is high for exactly the following cycle.
- exit1-DR event. At the action edge, {ir_in, sr} is pushed to the FIFO if not full.
  - Push while full with no same-cycle pop: entry dropped, FIFO unchanged, ovf <= 1.
  - Push while full with a same-cycle pop: push accepted, count unchanged.
- Pop rules.
  - Pop = cmd_valid & cmd_ready. cmd_ready while empty is ignored.
  - cmd_ir and cmd_jdo are driven from the head entry, stable while cmd_valid=1 and no pop.
  - Simultaneous push and pop when empty: the push lands; the pop is a no-op because cmd_valid=0.
  - fifo_count is updated at the same edge as a push/pop.
- Strobes.
  - At a pop edge, the popped entry is decoded.
  - take_action[cmd_ir] = cmd_jdo[ACT_BIT], else take_no_action[cmd_ir] = 1.
  - Strobes are registered: high for exactly the one cycle after the pop edge; all other bits 0.
  - Back-to-back pops give back-to-back strobes.
- Both toggles changing in the same cycle: both events are handled independently at the same edge.
- ovf: set on a dropped push, cleared by clr_ovf. Set has priority if both occur in the same cycle.
- Reset mid-operation: FIFO contents discarded, pending strobes cleared, priming restarts.

Test Plan:
- Reset → all outputs 0. Flip e1dr_tgl 0→1 during priming (within 3 cycles of reset release) → no push, fifo_count=0.
- Primed; ir_in=2'b01, sr=38'h04_0000_1234 (bit34=1); flip e1dr_tgl; cmd_ready=0 → cmd_valid=1 two edges later, cmd_ir=1, cmd_jdo=38'h04_0000_1234. Then cmd_ready=1 one cycle → take_action=4'b0010 for one cycle, cmd_valid=0.
- Entry with bit34=0, ir_in=2'b11; pop → take_no_action=4'b1000 for one cycle, take_action=0.
- Five e1dr toggles, cmd_ready=0 → fifo_count=4, ovf=1, the fifth entry is absent. Pulse clr_ovf → ovf=0.
- FIFO full, a push coinciding with a pop → fifo_count stays 4, the new entry is popped last, ovf stays 0.
- Toggle uir_tgl and e1dr_tgl in the same cycle with ir_in=2'b10 → ir_upd pulse, ir_q=2, FIFO entry cmd_ir=2, both at the same edge.

Source files
------------

// File: rtl/jtag_debug_cmd_sysclk_fifo_if.sv
// Command pop interface of the debug-slave sysclk stage.
// Handshake: a head entry transfers on every rising clk edge where cmd_valid and cmd_ready are both 1.
// While cmd_valid=1 and no transfer occurs, cmd_ir and cmd_jdo hold steady.
interface jtag_debug_cmd_sysclk_fifo_if #(
  parameter int IR_W = 2,
  parameter int SR_W = 38
) ();
  logic            cmd_valid;
  logic            cmd_ready;
  logic [IR_W-1:0] cmd_ir;
  logic [SR_W-1:0] cmd_jdo;

  modport master (output cmd_valid, output cmd_ir, output cmd_jdo, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_ir, input cmd_jdo, output cmd_ready);
endinterface

// File: rtl/jtag_debug_cmd_sysclk_fifo.sv
// System-clock side of the CPU debug slave: synchronises TCK-domain toggle events,
// buffers captured {ir, sr} commands in a FIFO and decodes popped commands into per-channel strobes.
module jtag_debug_cmd_sysclk_fifo #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int ACT_BIT     = 34,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  localparam int NUM_CH     = 2**IR_W,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  jtag_debug_cmd_sysclk_fifo_if.master cmd,
  input  logic                        uir_tgl,
  input  logic                        e1dr_tgl,
  input  logic [IR_W-1:0]             ir_in,
  input  logic [SR_W-1:0]             sr,
  output logic [IR_W-1:0]             ir_q,
  output logic                        ir_upd,
  output logic [NUM_CH-1:0]           take_action,
  output logic [NUM_CH-1:0]           take_no_action,
  output logic [CNT_W-1:0]            fifo_count,
  output logic                        ovf,
  input  logic                        clr_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam int EW = IR_W + SR_W;

  logic [SYNC_STAGES-1:0] uir_s, e1dr_s;
  logic                   uir_p, e1dr_p;
  logic [PW-1:0]          prime_cnt;
  logic                   primed, uir_evt, e1dr_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uir_s     <= '0;
      e1dr_s    <= '0;
      uir_p     <= 1'b0;
      e1dr_p    <= 1'b0;
      prime_cnt <= PW'(SYNC_STAGES + 1);
    end else begin
      uir_s  <= {uir_s[SYNC_STAGES-2:0], uir_tgl};
      e1dr_s <= {e1dr_s[SYNC_STAGES-2:0], e1dr_tgl};
      uir_p  <= uir_s[SYNC_STAGES-1];
      e1dr_p <= e1dr_s[SYNC_STAGES-1];
      if (prime_cnt != '0) prime_cnt <= prime_cnt - PW'(1);
    end
  end

  // Priming hides whatever level the toggles already hold when reset releases.
  assign primed   = (prime_cnt == '0);
  assign uir_evt  = primed & (uir_s[SYNC_STAGES-1] ^ uir_p);
  assign e1dr_evt = primed & (e1dr_s[SYNC_STAGES-1] ^ e1dr_p);

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [EW-1:0]     head;
  logic              full, pop, push, drop;
  logic [NUM_CH-1:0] head_ch;

  assign head    = mem[rd_ptr];
  assign full    = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign pop     = cmd.cmd_valid & cmd.cmd_ready;
  assign push    = e1dr_evt & (~full | pop);
  assign drop    = e1dr_evt & full & ~pop;
  assign head_ch = NUM_CH'(1) << head[SR_W +: IR_W];

  assign cmd.cmd_valid = (fifo_count != '0);
  assign cmd.cmd_ir    = cmd.cmd_valid ? head[SR_W +: IR_W] : '0;
  assign cmd.cmd_jdo   = cmd.cmd_valid ? head[SR_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ir_in, sr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      ovf            <= 1'b0;
      ir_q           <= '0;
      ir_upd         <= 1'b0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
      ir_upd <= uir_evt;
      if (uir_evt) ir_q <= ir_in;
      take_action    <= (pop &  head[ACT_BIT]) ? head_ch : '0;
      take_no_action <= (pop & ~head[ACT_BIT]) ? head_ch : '0;
    end
  end

endmodule
